contador_updown_bcd: RTL

- Parametrised successor to the single-button up-counter: N-bit modulo counter with up/down direction, synchronous preset load, wrap or saturate mode, and a terminal-count pulse.
- The raw push-button is debounced and edge-detected internally, so each press yields exactly one step.
- Drives two active-low 7-segment displays with the decimal tens/units of the count.
- Sits between board buttons/switches and the HEX displays. `count` is exported for benches.

---
 rtl/contador_updown_bcd.sv | 139 +++++++++++++
 1 files changed

// File: rtl/contador_updown_bcd.sv
`default_nettype none
// ============================================================================
//  contador_updown_bcd
//  Debounced push-button up/down modulo counter with preset load and
//  terminal-count pulse, driving two active-low 7-segment digits.
//  Revision: 1.0
// ============================================================================
module contador_updown_bcd #(
   parameter int N         = 6,
   parameter int MAX_VAL   = 59,
   parameter int DB_CYCLES = 4,
   parameter int WRAP      = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] initial_value,
   input  logic         load,
   input  logic         up_down,
   input  logic         step,
   output logic [N-1:0] count,
   output logic         tc,
   output logic [6:0]   seg1,
   output logic [6:0]   seg0
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] c_db_last = DB_W'(DB_CYCLES - 1);
   localparam logic [N-1:0]    c_max     = N'(MAX_VAL);

   logic            s1_q, s1_d;
   logic            s2_q, s2_d;
   logic            level_q, level_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            prev_q, prev_d;
   logic            pulse_q, pulse_d;
   logic [N-1:0]    count_q, count_d;
   logic            tc_q, tc_d;

   logic [6:0]      w_cnt7;
   logic [6:0]      w_tens;
   logic [6:0]      w_units;

   // Synchroniser, debouncer and rising-edge detector
   always_comb begin
      s1_d     = step;
      s2_d     = s1_q;
      level_d  = level_q;
      db_cnt_d = '0;
      if (s2_q != level_q) begin
         if (db_cnt_q == c_db_last) begin
            level_d  = s2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
      prev_d  = level_q;
      pulse_d = level_q & ~prev_q;
   end

   // Load outranks a step pulse arriving on the same edge
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = (initial_value > c_max) ? c_max : initial_value;
      end else if (pulse_q) begin
         if (up_down) begin
            if (count_q == c_max) begin
               count_d = (WRAP != 0) ? '0 : c_max;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q + N'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = (WRAP != 0) ? c_max : '0;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - N'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         level_q  <= 1'b0;
         db_cnt_q <= '0;
         prev_q   <= 1'b0;
         pulse_q  <= 1'b0;
         count_q  <= '0;
         tc_q     <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         level_q  <= level_d;
         db_cnt_q <= db_cnt_d;
         prev_q   <= prev_d;
         pulse_q  <= pulse_d;
         count_q  <= count_d;
         tc_q     <= tc_d;
      end
   end

   function automatic logic [6:0] seg_of(input logic [6:0] d);
      logic [6:0] s;
      case (d)
         7'd0:    s = 7'b1000000;
         7'd1:    s = 7'b1111001;
         7'd2:    s = 7'b0100100;
         7'd3:    s = 7'b0110000;
         7'd4:    s = 7'b0011001;
         7'd5:    s = 7'b0010010;
         7'd6:    s = 7'b0000010;
         7'd7:    s = 7'b1111000;
         7'd8:    s = 7'b0000000;
         7'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Count never exceeds 99, so seven bits hold it for any legal N
   always_comb begin
      w_cnt7  = 7'(count_q);
      w_tens  = w_cnt7 / 7'd10;
      w_units = w_cnt7 % 7'd10;
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign seg1  = seg_of(w_tens);
   assign seg0  = seg_of(w_units);

endmodule
`default_nettype wire
